seg_scan_mux: RTL and testbench

Time-multiplexed scanner for the Nexys A7 eight-digit seven-segment display. Sits directly upstream of the BCD-to-seven-segment decoder:
- Holds a frame of up to eight 4-bit digit codes and steps through them at a fixed refresh rate.
- Presents one code per slot on `bcd_out`, which feeds the decoder.
- Drives the matching active-low anode and decimal point.
- Blanks disabled digits and inserts a guard interval at each slot change to suppress ghosting.

---
 rtl/seg_disp_pkg.sv | 18 +
 rtl/refresh_tick.sv | 30 +++
 rtl/seg_scan_mux.sv | 95 +++++++++
 tb/tb_seg_scan_mux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Purpose: shared constants and types for the seven-segment display path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default clock rate and digit count, the active-low blank
// pattern and the 4-bit digit code type used by the scanner.
package seg_disp_pkg;

  localparam int CLK_HZ       = 100_000_000;
  localparam int N_DIGITS_DEF = 8;
  // One digit slot per millisecond at the default clock.
  localparam int TICK_DIV_DEF = CLK_HZ / 1000;

  // Active-low anodes: all ones means every digit is dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef logic [3:0] digit_code_t;

endpackage

// File: rtl/refresh_tick.sv
// Purpose: free-running slot counter with a terminal-count tick.
// Latency: tick is combinational from the registered count (asserted on cnt == TICK_DIV-1).
// Backpressure: none; counts every cycle while out of reset.
// Ports: clk, rst (sync, active-high), cnt (current slot position), tick (one-cycle pulse).
module refresh_tick #(
  parameter int TICK_DIV = 100000,
  localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign cnt   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Purpose: time-multiplexed scanner for an N-digit seven-segment display.
// Latency: outputs are registered, one cycle behind the slot counter and digit index.
// Backpressure: none; inputs are sampled into a shadow frame only at frame boundaries.
// Ports: clk, rst (sync, active-high); value/digit_en/dp_in frame inputs;
//        bcd_out to the decoder, anodes (active-low), dp_n (active-low), digit_sel.
module seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int GUARD    = 4,
  localparam int SEL_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [3:0]            bcd_out,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  dp_n,
  output logic [SEL_W-1:0]      digit_sel
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [N_DIGITS-1:0] ALL_OFF = SEG_OFF[N_DIGITS-1:0];

  logic [CNT_W-1:0] cnt;
  logic             tick;

  refresh_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_refresh_tick (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .tick (tick)
  );

  logic [SEL_W-1:0]                 idx_q, idx_d;
  logic                             first_q;
  digit_code_t [N_DIGITS-1:0]       val_sh_q;
  logic [N_DIGITS-1:0]              en_sh_q;
  logic [N_DIGITS-1:0]              dp_sh_q;

  logic                             frame_end;
  logic                             load;
  logic                             in_guard;
  logic [N_DIGITS-1:0]              one_hot;
  logic [N_DIGITS-1:0]              anodes_d;
  logic                             dp_n_d;

  // The last slot's tick closes the frame; with one digit every tick does,
  // which also pins idx at 0.
  assign frame_end = tick && (idx_q == SEL_W'(N_DIGITS - 1));
  assign idx_d     = frame_end ? '0 : (tick ? idx_q + 1'b1 : idx_q);

  // Shadow frame reloads right after reset and at every frame boundary, so
  // mid-frame input changes never tear the displayed frame.
  assign load = first_q || frame_end;

  // Signed compare so a zero guard is simply never true.
  assign in_guard = (int'(cnt) < GUARD);

  assign one_hot  = N_DIGITS'(1) << idx_q;
  assign anodes_d = (in_guard || !en_sh_q[idx_q]) ? ALL_OFF : ~one_hot;
  assign dp_n_d   = in_guard ? 1'b1 : ~(dp_sh_q[idx_q] & en_sh_q[idx_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      first_q   <= 1'b1;
      val_sh_q  <= '0;
      en_sh_q   <= '0;
      dp_sh_q   <= '0;
      bcd_out   <= '0;
      anodes    <= ALL_OFF;
      dp_n      <= 1'b1;
      digit_sel <= '0;
    end else begin
      idx_q <= idx_d;
      if (load) begin
        first_q  <= 1'b0;
        val_sh_q <= value;
        en_sh_q  <= digit_en;
        dp_sh_q  <= dp_in;
      end
      bcd_out   <= val_sh_q[idx_q];
      anodes    <= anodes_d;
      dp_n      <= dp_n_d;
      digit_sel <= idx_q;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int GA = 2;
  localparam int GB = 0;
  localparam int NT = N * T;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;

  logic [3:0]  a_bcd, b_bcd;
  logic [3:0]  a_an, b_an;
  logic        a_dp, b_dp;
  logic [1:0]  a_sel, b_sel;

  seg_scan_mux #(.N_DIGITS(N), .TICK_DIV(T), .GUARD(GA)) u_dut_a (
    .clk(clk), .rst(rst), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .bcd_out(a_bcd), .anodes(a_an), .dp_n(a_dp), .digit_sel(a_sel)
  );

  seg_scan_mux #(.N_DIGITS(N), .TICK_DIV(T), .GUARD(GB)) u_dut_b (
    .clk(clk), .rst(rst), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .bcd_out(b_bcd), .anodes(b_an), .dp_n(b_dp), .digit_sel(b_sel)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: everything follows from the absolute position since
  // reset release. Position p shows slot (p/T)%N at offset p%T, using the
  // frame sampled when p==0 or at the last cycle of the previous frame.
  int          cur_pos = 0;
  logic [15:0] sh_v = '0;
  logic [3:0]  sh_e = '0;
  logic [3:0]  sh_d = '0;
  logic [1:0]  e_sel;
  logic [3:0]  e_bcd, ea_an, eb_an;
  logic        ea_dp, eb_dp;

  task automatic model_edge(input logic r, input logic [15:0] v, input logic [3:0] e,
                            input logic [3:0] d);
    int slot, off;
    logic [3:0] oh;
    if (r) begin
      e_sel = 0; e_bcd = 0; ea_an = 4'hF; eb_an = 4'hF; ea_dp = 1; eb_dp = 1;
      sh_v = '0; sh_e = '0; sh_d = '0; cur_pos = 0;
    end else begin
      slot  = (cur_pos / T) % N;
      off   = cur_pos % T;
      oh    = 4'b0001 << slot;
      e_sel = 2'(slot);
      e_bcd = sh_v[slot*4 +: 4];
      ea_an = (off < GA || !sh_e[slot]) ? 4'hF : ~oh;
      eb_an = (off < GB || !sh_e[slot]) ? 4'hF : ~oh;
      ea_dp = (off < GA) ? 1'b1 : ~(sh_d[slot] & sh_e[slot]);
      eb_dp = (off < GB) ? 1'b1 : ~(sh_d[slot] & sh_e[slot]);
      if (cur_pos == 0 || (cur_pos + 1) % NT == 0) begin
        sh_v = v; sh_e = e; sh_d = d;
      end
      cur_pos++;
    end
  endtask

  logic [15:0] cv;
  logic [3:0]  ce, cd;

  task automatic step(input logic r);
    rst = r; value = cv; digit_en = ce; dp_in = cd;
    model_edge(r, cv, ce, cd);
    @(negedge clk);
    check("a_sel", a_sel, e_sel);
    check("a_bcd", a_bcd, e_bcd);
    check("a_an",  a_an,  ea_an);
    check("a_dp",  a_dp,  ea_dp);
    check("b_sel", b_sel, e_sel);
    check("b_bcd", b_bcd, e_bcd);
    check("b_an",  b_an,  eb_an);
    check("b_dp",  b_dp,  eb_dp);
  endtask

  // Step until the model's next position is congruent to target mod 'modulus'.
  task automatic run_to(input int target, input int modulus);
    int n;
    n = ((target - cur_pos) % modulus + modulus) % modulus;
    repeat (n) step(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_en, bad, bad2, lit, gap;
    logic [3:0] oh;

    cv = 16'h4321; ce = 4'hF; cd = 4'h0;

    // Reset behaviour
    repeat (3) step(1'b1);
    check("rst_an",  a_an,  4'hF);
    check("rst_dp",  a_dp,  1);
    check("rst_bcd", a_bcd, 0);
    check("rst_sel", a_sel, 0);

    // First enable and full scan
    first_en = 0;
    for (int k = 1; k <= 32; k++) begin
      step(1'b0);
      if (first_en == 0 && a_an == 4'b1110 && a_bcd == 4'd1) first_en = k;
    end
    check("first_en_cycle", first_en, 3);

    // No tearing: change value while slot 1 of frame 1 is on
    run_to(43, 1000);
    cv = 16'h8765;
    run_to(52, 1000);
    check("notear_s2", a_bcd, 3);
    run_to(60, 1000);
    check("notear_s3", a_bcd, 4);
    run_to(68, 1000);
    check("newframe_s0", a_bcd, 5);
    run_to(92, 1000);
    check("newframe_s3", a_bcd, 8);

    // Blanking and decimal point
    ce = 4'b0101; cd = 4'b0001;
    repeat (33) step(1'b0);
    bad = 0; bad2 = 0; lit = 0;
    for (int k = 0; k < 64; k++) begin
      step(1'b0);
      if ((a_sel == 2'd1 || a_sel == 2'd3) && (a_an != 4'hF || a_dp != 1'b1)) bad++;
      if (a_sel == 2'd0 && ((a_dp == 1'b0) != (a_an == 4'b1110))) bad2++;
      if (a_dp == 1'b0) lit++;
    end
    check("blank_slots", bad, 0);
    check("dp_with_anode", bad2, 0);
    check("dp_lit_cycles", lit, 12);

    // Reset at cnt=5 of slot 2
    ce = 4'hF; cd = 4'h0;
    run_to(21, NT);
    cv = 16'hA9C3;
    step(1'b1);
    check("midrst_an",  a_an,  4'hF);
    check("midrst_dp",  a_dp,  1);
    check("midrst_bcd", a_bcd, 0);
    check("midrst_sel", a_sel, 0);
    repeat (3) step(1'b0);
    check("restart_an",  a_an,  4'b1110);
    check("restart_bcd", a_bcd, 4'h3);

    // Guard disabled: no dark cycle between enabled digits
    run_to(NT, 1000);
    gap = 0;
    for (int k = 0; k < NT; k++) begin
      step(1'b0);
      oh = 4'b0001 << b_sel;
      if (b_an != ~oh) gap++;
    end
    check("g0_no_gap", gap, 0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(5, 0) == 0) cv = 16'($urandom);
      if ($urandom_range(9, 0) == 0) ce = 4'($urandom);
      if ($urandom_range(9, 0) == 0) cd = 4'($urandom);
      step($urandom_range(119, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
